// File: rtl/hazard_sequencer_pkg.sv
// hazard_sequencer_pkg: shared state encoding, forward selects and sequencer context
package hazard_sequencer_pkg;

    typedef enum logic [1:0] {RUN = 2'd0, DEP_WAIT = 2'd1, MEM_WAIT = 2'd2} state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // cnt = stall cycles still owed in DEP_WAIT; rel = next RUN cycle is the branch release cycle
    typedef struct packed {
        state_t     st;
        logic [1:0] cnt;
        logic       rel;
    } ctx_t;

    localparam ctx_t CTX_RST = '{st: RUN, cnt: 2'd0, rel: 1'b0};

endpackage

// File: rtl/hazard_match.sv
// hazard_match: per-operand branch wait need and release select from EX/MEM destinations
// in:  r/used (operand), ex_rd/ex_wen/ex_is_load, mem_rd/mem_wen/mem_is_load
// out: need (0..2 cycles), sel (forward source once released), load_use (EX load hit)
module hazard_match
    import hazard_sequencer_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] r,
    input  logic            used,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_wen,
    input  logic            ex_is_load,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_wen,
    input  logic            mem_is_load,
    output logic [1:0]      need,
    output logic [1:0]      sel,
    output logic            load_use
);

    logic hit_e, hit_m;

    assign hit_e    = used && r != '0 && r == ex_rd && ex_wen;
    assign hit_m    = used && r != '0 && r == mem_rd && mem_wen;
    assign load_use = hit_e && ex_is_load;
    assign need     = hit_e ? (ex_is_load ? 2'd2 : 2'd1) : (hit_m && mem_is_load) ? 2'd1 : 2'd0;
    assign sel      = hit_e ? (ex_is_load ? FWD_WB : FWD_MEM) : hit_m ? (mem_is_load ? FWD_WB : FWD_MEM) : FWD_RF;

endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline-control FSM for load-use/branch hazards, dmem freeze and redirect flush
// in:  clk, rstn, ID operands/branch flag, EX/MEM destinations, dmem_req/dmem_ready, redirect_id
// out: stall_if/id/ex/mem, bubble_ex/wb, flush_id, br_fwd_a/b, stall_cnt, flush_cnt
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int RA_W  = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             id_is_br,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic             ex_wen,
    input  logic             ex_is_load,
    input  logic [RA_W-1:0]  mem_rd,
    input  logic             mem_wen,
    input  logic             mem_is_load,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             redirect_id,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             bubble_ex,
    output logic             bubble_wb,
    output logic             flush_id,
    output logic [1:0]       br_fwd_a,
    output logic [1:0]       br_fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [1:0] need_a, need_b, sel_a, sel_b, need, lat_a, lat_b, nxt_lat_a, nxt_lat_b;
    logic       lu_a, lu_b, frz;
    ctx_t       ctx, saved, cur, nxt;

    hazard_match #(.RA_W(RA_W)) u_match_a (
        .r(id_rs1), .used(id_rs1_used), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_is_load(mem_is_load),
        .need(need_a), .sel(sel_a), .load_use(lu_a)
    );

    hazard_match #(.RA_W(RA_W)) u_match_b (
        .r(id_rs2), .used(id_rs2_used), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_is_load(mem_is_load),
        .need(need_b), .sel(sel_b), .load_use(lu_b)
    );

    assign frz  = dmem_req && !dmem_ready;
    // Once the memory answers, the saved context acts in that same cycle so the
    // instruction held in ID is never released without its hazard being honoured.
    assign cur  = (ctx.st == MEM_WAIT) ? saved : ctx;
    assign need = (need_a > need_b) ? need_a : need_b;

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        bubble_ex = 1'b0;
        bubble_wb = 1'b0;
        br_fwd_a  = FWD_RF;
        br_fwd_b  = FWD_RF;
        nxt       = cur;
        nxt_lat_a = lat_a;
        nxt_lat_b = lat_b;
        if (!rstn) begin
            nxt = CTX_RST;
        end else if (frz) begin
            {stall_if, stall_id, stall_ex, stall_mem, bubble_wb} = '1;
            nxt.st = MEM_WAIT;
        end else if (cur.st == DEP_WAIT) begin
            {stall_if, stall_id, bubble_ex} = '1;
            nxt.cnt = cur.cnt - 2'd1;
            nxt.st  = (cur.cnt <= 2'd1) ? RUN : DEP_WAIT;
            nxt.rel = cur.cnt <= 2'd1;
        end else if (cur.rel) begin
            br_fwd_a  = lat_a;
            br_fwd_b  = lat_b;
            nxt.rel   = 1'b0;
            nxt_lat_a = FWD_RF;
            nxt_lat_b = FWD_RF;
        end else if (id_valid && !id_is_br) begin
            {stall_if, stall_id, bubble_ex} = {3{lu_a || lu_b}};
        end else if (id_valid && need != 2'd0) begin
            // The entry cycle is the first stall, so DEP_WAIT owes need-1 more.
            {stall_if, stall_id, bubble_ex} = '1;
            nxt.cnt   = need - 2'd1;
            nxt.st    = (need == 2'd1) ? RUN : DEP_WAIT;
            nxt.rel   = need == 2'd1;
            nxt_lat_a = sel_a;
            nxt_lat_b = sel_b;
        end else if (id_valid) begin
            br_fwd_a = sel_a;
            br_fwd_b = sel_b;
        end
        flush_id = rstn && redirect_id && !stall_id;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctx       <= CTX_RST;
            saved     <= CTX_RST;
            lat_a     <= FWD_RF;
            lat_b     <= FWD_RF;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            ctx       <= nxt;
            saved     <= frz ? cur : saved;
            lat_a     <= nxt_lat_a;
            lat_b     <= nxt_lat_b;
            stall_cnt <= stall_cnt + CNT_W'(stall_id);
            flush_cnt <= flush_cnt + CNT_W'(flush_id);
        end
    end

endmodule
